// File: rtl/retire.sv
// retire: writeback/retire stage; filters stale results by tag, forms the register
// write strobe/data and jump redirect, and counts retired instructions.
package retire_pkg;
    typedef enum logic [2:0] {adder, shifter, multiplier, memory, branch} xu;
    typedef enum logic [2:0] {OP0, OP1, OP2, OP3, OP4, OP5, OP6, OP7} instruction_type;
endpackage

module retire
    import retire_pkg::*;
#(
    parameter int TAG_W     = 4,
    parameter int WB_STAGES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_in,
    input  logic [TAG_W-1:0] tag_in,
    input  xu                xu_sel_in,
    input  instruction_type  i_in,
    input  logic [31:0]      result_in,
    input  logic [31:0]      mem_data,
    input  logic             jump_in,
    input  logic [31:0]      jump_target,
    output logic             we,
    output logic [31:0]      regD,
    output logic             jump,
    output logic [31:0]      new_pc,
    output logic [TAG_W-1:0] tag_out,
    output logic [31:0]      instret
);
    typedef struct packed {
        logic        we;
        logic [31:0] data;
        logic        jump;
        logic [31:0] pc;
        logic        cnt;
    } slot_t;

    logic        accept, store, is_mem;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    slot_t       slot, last_in;
    slot_t       pipe [WB_STAGES];

    always_comb begin
        accept  = valid_in && (tag_in == tag_out);
        is_mem  = xu_sel_in == memory;
        store   = is_mem && (i_in inside {OP5, OP6, OP7});
        ld_byte = mem_data[{result_in[1:0], 3'b000} +: 8];
        ld_half = result_in[1] ? mem_data[31:16] : mem_data[15:0];
        ld_data = i_in == OP0 ? {{24{ld_byte[7]}}, ld_byte} :
                  i_in == OP1 ? {24'b0, ld_byte} :
                  i_in == OP2 ? {{16{ld_half[15]}}, ld_half} :
                  i_in == OP3 ? {16'b0, ld_half} : mem_data;
        slot.we   = accept && !store;
        slot.data = slot.we ? (is_mem ? ld_data : result_in) : 32'b0;
        slot.jump = accept && xu_sel_in == branch && jump_in;
        slot.pc   = slot.jump ? jump_target : 32'b0;
        slot.cnt  = accept;
    end

    // instret advances on the edge that moves a slot into the output stage
    if (WB_STAGES == 1) begin : g_one
        assign last_in = slot;
    end else begin : g_many
        assign last_in = pipe[WB_STAGES-2];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tag_out <= '0;
            instret <= '0;
            for (int s = 0; s < WB_STAGES; s++) pipe[s] <= '0;
        end else begin
            tag_out <= tag_out + TAG_W'(slot.jump);
            instret <= instret + 32'(last_in.cnt);
            pipe[0] <= slot;
            for (int s = 1; s < WB_STAGES; s++) pipe[s] <= pipe[s-1];
        end
    end

    assign we     = pipe[WB_STAGES-1].we;
    assign regD   = pipe[WB_STAGES-1].data;
    assign jump   = pipe[WB_STAGES-1].jump;
    assign new_pc = pipe[WB_STAGES-1].pc;
endmodule

// File: tb/tb_retire.sv
// tb_retire: directed self-checking bench for the retire stage (WB_STAGES = 1).
module tb_retire;
    import retire_pkg::*;

    logic            clk = 0, reset = 0;
    logic            valid_in = 0, jump_in = 0;
    logic [3:0]      tag_in = 0;
    xu               xu_sel_in = adder;
    instruction_type i_in = OP0;
    logic [31:0]     result_in = 0, mem_data = 0, jump_target = 0;
    logic            we, jump;
    logic [31:0]     regD, new_pc, instret;
    logic [3:0]      tag_out;
    int              pass = 0, total = 0;
    logic [31:0]     exp_cnt = 0;

    retire #(.TAG_W(4), .WB_STAGES(1)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .tag_in(tag_in),
        .xu_sel_in(xu_sel_in), .i_in(i_in), .result_in(result_in), .mem_data(mem_data),
        .jump_in(jump_in), .jump_target(jump_target), .we(we), .regD(regD),
        .jump(jump), .new_pc(new_pc), .tag_out(tag_out), .instret(instret)
    );

    always #5 clk = ~clk;

    // drive one slot at a negedge; outputs for it are visible at the next negedge
    task automatic drive(input logic v, input logic [3:0] t, input xu x, input instruction_type op,
                         input logic [31:0] res, input logic [31:0] md, input logic j,
                         input logic [31:0] tgt);
        valid_in = v; tag_in = t; xu_sel_in = x; i_in = op;
        result_in = res; mem_data = md; jump_in = j; jump_target = tgt;
        @(negedge clk);
        valid_in = 0; jump_in = 0;
    endtask

    task automatic test_reset;
        reset = 0;
        @(negedge clk);
        total++; if (we !== 1'b0) $display("FAIL reset_we got %0b want 0", we); else pass++;
        total++; if (regD !== 32'h0) $display("FAIL reset_regD got %h want 0", regD); else pass++;
        total++; if (jump !== 1'b0 || new_pc !== 32'h0) $display("FAIL reset_jump got %0b/%h want 0/0", jump, new_pc); else pass++;
        total++; if (tag_out !== 4'h0 || instret !== 32'h0) $display("FAIL reset_tag_cnt got %h/%0d want 0/0", tag_out, instret); else pass++;
        reset = 1;
        @(negedge clk);
    endtask

    task automatic test_adder;
        drive(1, 0, adder, OP0, 32'h1234, 0, 0, 0);
        exp_cnt++;
        total++; if (we !== 1'b1) $display("FAIL adder_we got %0b want 1", we); else pass++;
        total++; if (regD !== 32'h00001234) $display("FAIL adder_regD got %h want 00001234", regD); else pass++;
        total++; if (instret !== exp_cnt) $display("FAIL adder_instret got %0d want %0d", instret, exp_cnt); else pass++;
    endtask

    task automatic test_loads;
        instruction_type ops [5] = '{OP0, OP1, OP2, OP3, OP4};
        logic [31:0] exp [5] = '{32'hFFFFFF80, 32'h00000080, 32'hFFFF80FF, 32'h000080FF, 32'h80FF7F01};
        for (int k = 0; k < 5; k++) begin
            drive(1, 0, memory, ops[k], 32'h103, 32'h80FF7F01, 0, 0);
            exp_cnt++;
            total++; if (we !== 1'b1 || regD !== exp[k]) $display("FAIL load_op%0d got we=%0b regD=%h want 1/%h", k, we, regD, exp[k]); else pass++;
        end
        total++; if (instret !== exp_cnt) $display("FAIL load_instret got %0d want %0d", instret, exp_cnt); else pass++;
    endtask

    task automatic test_store;
        drive(1, 0, memory, OP7, 32'h100, 32'hDEADBEEF, 0, 0);
        exp_cnt++;
        total++; if (we !== 1'b0 || regD !== 32'h0) $display("FAIL store_we got we=%0b regD=%h want 0/0", we, regD); else pass++;
        total++; if (instret !== exp_cnt) $display("FAIL store_instret got %0d want %0d", instret, exp_cnt); else pass++;
    endtask

    task automatic test_jump;
        drive(1, 0, branch, OP0, 32'h44, 0, 1, 32'h200);
        exp_cnt++;
        total++; if (jump !== 1'b1 || new_pc !== 32'h200) $display("FAIL jump_pulse got %0b/%h want 1/00000200", jump, new_pc); else pass++;
        total++; if (we !== 1'b1 || regD !== 32'h44) $display("FAIL jump_link got we=%0b regD=%h want 1/00000044", we, regD); else pass++;
        total++; if (tag_out !== 4'h1) $display("FAIL jump_tag got %h want 1", tag_out); else pass++;
        for (int k = 0; k < 3; k++) begin
            drive(1, 0, adder, OP0, 32'h55 + k, 0, 0, 0);
            total++; if (we !== 1'b0 || jump !== 1'b0) $display("FAIL stale_%0d got we=%0b jump=%0b want 0/0", k, we, jump); else pass++;
        end
        drive(1, 0, branch, OP0, 32'h0, 0, 1, 32'h300);
        total++; if (jump !== 1'b0 || tag_out !== 4'h1) $display("FAIL stale_branch got jump=%0b tag=%h want 0/1", jump, tag_out); else pass++;
        drive(1, 1, adder, OP0, 32'h77, 0, 0, 0);
        exp_cnt++;
        total++; if (we !== 1'b1 || regD !== 32'h77) $display("FAIL newtag got we=%0b regD=%h want 1/00000077", we, regD); else pass++;
        total++; if (instret !== exp_cnt) $display("FAIL jump_instret got %0d want %0d", instret, exp_cnt); else pass++;
    endtask

    task automatic test_wrap;
        reset = 0;
        @(negedge clk);
        reset = 1;
        exp_cnt = 0;
        for (int k = 0; k < 16; k++) begin
            drive(1, 4'(k), branch, OP0, 32'h0, 0, 1, 32'h1000 + k);
            exp_cnt++;
            total++; if (jump !== 1'b1 || tag_out !== 4'(k + 1)) $display("FAIL wrap_%0d got jump=%0b tag=%h want 1/%h", k, jump, tag_out, 4'(k + 1)); else pass++;
        end
        drive(1, 0, adder, OP0, 32'hABC, 0, 0, 0);
        exp_cnt++;
        total++; if (we !== 1'b1 || regD !== 32'hABC) $display("FAIL wrap_accept got we=%0b regD=%h want 1/00000ABC", we, regD); else pass++;
        total++; if (instret !== exp_cnt) $display("FAIL wrap_instret got %0d want %0d", instret, exp_cnt); else pass++;
    endtask

    task automatic test_reset_inflight;
        drive(1, 0, branch, OP0, 32'h9, 0, 1, 32'h400);
        valid_in = 1; tag_in = 1; xu_sel_in = adder; result_in = 32'h11;
        @(negedge clk);
        @(posedge clk);
        #2 reset = 0;
        #1;
        total++; if (we !== 1'b0 || regD !== 32'h0 || jump !== 1'b0 || new_pc !== 32'h0) $display("FAIL async_reset got we=%0b regD=%h jump=%0b pc=%h want 0", we, regD, jump, new_pc); else pass++;
        total++; if (tag_out !== 4'h0 || instret !== 32'h0) $display("FAIL async_reset_cnt got tag=%h instret=%0d want 0/0", tag_out, instret); else pass++;
        @(negedge clk);
        valid_in = 0;
        reset = 1;
        @(negedge clk);
        total++; if (we !== 1'b0 || instret !== 32'h0) $display("FAIL late_we got we=%0b instret=%0d want 0/0", we, instret); else pass++;
        drive(1, 0, adder, OP0, 32'h22, 0, 0, 0);
        total++; if (we !== 1'b1 || regD !== 32'h22) $display("FAIL post_reset got we=%0b regD=%h want 1/00000022", we, regD); else pass++;
    endtask

    initial begin
        test_reset;
        test_adder;
        test_loads;
        test_store;
        test_jump;
        test_wrap;
        test_reset_inflight;
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
